// File: rtl/coherent_dcache.sv
// coherent_dcache: per-core, direct-mapped, write-back L1 data cache with MSI
// coherence. Each of SETS lines holds a tag, a 2-bit MSI state and two words.
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   dmemREN/dmemWEN/dmemaddr/
//   dmemstore/dmemload/dhit         datapath load/store port
//   halt/flushed                    flush-on-halt handshake (flushed sticky)
//   dREN/dWEN/daddr/dstore/dload/
//   dwait                           memory controller word transfer port
//   ccwait/ccinv/ccsnoopaddr/
//   cctrans/ccwrite/evict           coherence request and snoop response
module coherent_dcache #(
  parameter int SETS  = 16,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        cctrans,
  output logic        ccwrite,
  output logic        evict
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH_WB0, FLUSH_WB1, DONE
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_st  [SETS];
  logic [TW-1:0]   r_tag [SETS];
  logic [31:0]     r_d0  [SETS];
  logic [31:0]     r_d1  [SETS];
  logic [IW-1:0]   r_cnt;
  logic [28:0]     r_blk;    // block address of the outstanding miss
  logic            r_wen;    // outstanding miss is a store
  logic [31:0]     r_fill0;  // first fill word, held until the block completes

  logic [IW-1:0]   w_idx, w_ridx, w_sidx;
  logic            w_tag_eq, w_req, w_cond, w_dhit, w_vic_dirty, w_miss_start;
  logic            w_s_hit, w_s_m;
  logic [31:0]     w_word;
  logic            w_unused;

  assign w_idx    = dmemaddr[3 +: IW];
  assign w_ridx   = r_blk[IW-1:0];
  assign w_sidx   = ccsnoopaddr[3 +: IW];
  assign w_tag_eq = (r_tag[w_idx] == dmemaddr[31:3+IW]);
  assign w_req    = dmemREN | dmemWEN;
  // A store needs ownership (M); a load is satisfied by S or M.
  assign w_cond   = w_tag_eq && (dmemWEN ? (r_st[w_idx] == ST_M)
                                         : (r_st[w_idx] != ST_I));
  assign w_dhit   = (r_state == IDLE) && !halt && !ccwait && w_req && w_cond;
  assign w_vic_dirty  = (r_st[w_idx] == ST_M) && !w_tag_eq;
  // A snoop in flight holds off the miss so the request simply waits.
  assign w_miss_start = (r_state == IDLE) && !halt && !ccwait && w_req && !w_cond;
  assign w_word   = dmemaddr[2] ? r_d1[w_idx] : r_d0[w_idx];

  assign dhit     = w_dhit;
  assign dmemload = w_dhit ? w_word : 32'h0;

  assign w_s_hit  = (r_tag[w_sidx] == ccsnoopaddr[31:3+IW]) && (r_st[w_sidx] != ST_I);
  assign w_s_m    = ccwait && w_s_hit && (r_st[w_sidx] == ST_M);

  assign w_unused = ^{dmemaddr[1:0], ccsnoopaddr[1:0], 32'(CPUID)};

  always_comb begin
    w_next  = r_state;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = 32'h0;
    dstore  = 32'h0;
    cctrans = 1'b0;
    ccwrite = 1'b0;
    evict   = 1'b0;
    flushed = 1'b0;
    case (r_state)
      IDLE: begin
        if (halt)              w_next = FLUSH_CHK;
        else if (w_miss_start) w_next = w_vic_dirty ? WB0 : FETCH0;
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        evict  = 1'b1;
        daddr  = {r_tag[w_ridx], w_ridx, (r_state == WB1), 2'b00};
        dstore = (r_state == WB1) ? r_d1[w_ridx] : r_d0[w_ridx];
        if (!dwait) w_next = (r_state == WB1) ? FETCH0 : WB1;
      end
      FETCH0, FETCH1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = r_wen;
        daddr   = {r_blk, (r_state == FETCH1), 2'b00};
        if (!dwait) w_next = (r_state == FETCH1) ? IDLE : FETCH1;
      end
      FLUSH_CHK: begin
        if (r_st[r_cnt] == ST_M)         w_next = FLUSH_WB0;
        else if (r_cnt == IW'(SETS - 1)) w_next = DONE;
      end
      FLUSH_WB0, FLUSH_WB1: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_cnt], r_cnt, (r_state == FLUSH_WB1), 2'b00};
        dstore = (r_state == FLUSH_WB1) ? r_d1[r_cnt] : r_d0[r_cnt];
        if (!dwait) begin
          if (r_state == FLUSH_WB0)        w_next = FLUSH_WB1;
          else if (r_cnt == IW'(SETS - 1)) w_next = DONE;
          else                             w_next = FLUSH_CHK;
        end
      end
      DONE:    flushed = 1'b1;
      default: w_next = IDLE;
    endcase
    // Snoop response is independent of the controller phase.
    if (w_s_m) begin
      cctrans = 1'b1;
      dstore  = ccsnoopaddr[2] ? r_d1[w_sidx] : r_d0[w_sidx];
    end
  end

  // Control state: FSM, flush counter, line states
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < SETS; i++) r_st[i] <= ST_I;
    end else begin
      r_state <= w_next;
      if (ccwait && w_s_hit) begin
        if (ccinv)                     r_st[w_sidx] <= ST_I;
        else if (r_st[w_sidx] == ST_M) r_st[w_sidx] <= ST_S;
      end
      // Controller updates come after the snoop so a fill or victim
      // invalidation on the same set takes precedence.
      case (r_state)
        WB1:    if (!dwait) r_st[w_ridx] <= ST_I;
        FETCH1: if (!dwait) r_st[w_ridx] <= r_wen ? ST_M : ST_S;
        FLUSH_CHK: if (r_st[r_cnt] != ST_M) begin
          r_st[r_cnt] <= ST_I;
          r_cnt       <= r_cnt + 1'b1;
        end
        FLUSH_WB1: if (!dwait) begin
          r_st[r_cnt] <= ST_I;
          r_cnt       <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data path: miss address capture, fill buffer, tag and data arrays
  always_ff @(posedge CLK) begin
    if (w_miss_start) begin
      r_blk <= dmemaddr[31:3];
      r_wen <= dmemWEN;
    end
    if (r_state == FETCH0 && !dwait) r_fill0 <= dload;
    if (r_state == FETCH1 && !dwait) begin
      r_tag[w_ridx] <= r_blk[28:IW];
      r_d0[w_ridx]  <= r_fill0;
      r_d1[w_ridx]  <= dload;
    end
    if (w_dhit && dmemWEN) begin
      if (dmemaddr[2]) r_d1[w_idx] <= dmemstore;
      else             r_d0[w_idx] <= dmemstore;
    end
  end
endmodule

// File: doc/coherent_dcache.md
# coherent_dcache

Per-core, direct-mapped, write-back L1 data cache with MSI coherence for the dual-core pipeline. Upstream it serves the datapath's load/store port. Downstream it is the cache end of the coherence/arbitration interface: it issues block fills and writebacks to the memory controller, and it answers that controller's snoops. On halt it flushes every dirty line, then raises `flushed`.

## Interface
- `SETS`, 16: number of lines. Index is `dmemaddr[6:3]`, tag is `[31:7]`, word-in-block is `[2]`.
- `CPUID`, 0: core number. Used only for trace identification.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `dmemREN` in 1: datapath load request.
- `dmemWEN` in 1: datapath store request.
- `dmemaddr` in 32: datapath word address.
- `dmemstore` in 32: store data.
- `dmemload` out 32: load data. Valid when `dhit`=1.
- `dhit` out 1: request satisfied this cycle.
- `halt` in 1: core halted. Starts the flush.
- `flushed` out 1: flush complete. Sticky until reset.
- `dREN` out 1: memory read request.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory word address.
- `dstore` out 32: memory write data, or snoop supply data.
- `dload` in 32: memory or cache-to-cache data.
- `dwait` in 1: 0 completes the current word.
- `ccwait` in 1: snoop in progress on this cache.
- `ccinv` in 1: snoop is invalidating.
- `ccsnoopaddr` in 32: snooped word address.
- `cctrans` out 1: meaning depends on phase (see Operation).
  - Requesting: a coherence fill is requested.
  - Under snoop: this cache is supplying M data.
- `ccwrite` out 1: the fill requests exclusive (M) ownership.
- `evict` out 1: a dirty victim writeback is in progress.

## Operation
- Each line holds: tag, a 2-bit MSI state (I/S/M), and 2 data words.
- **Hit conditions:**
  - Read hit: the line is S or M.
  - Write hit: the line is M.
  - A write to an S line is an upgrade miss.
- **On a hit:** `dhit`=1 combinationally. `dmemload` is the word selected by `dmemaddr[2]`. A write hit updates the word at the clock edge.
- **Controller FSM states:** IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH_WB0, FLUSH_WB1, DONE.
- **IDLE:**
  - Read or write miss with a dirty victim (M, tag differs) → WB0.
  - Any other miss → FETCH0.
  - `halt` → FLUSH_CHK. Pending requests are ignored.
- **WB0/WB1:**
  - Outputs: `dWEN`=1, `evict`=1, `daddr` = victim base + 0/4, `dstore` = victim word 0/1.
  - Advance on `dwait`=0.
  - WB1 → FETCH0.
  - The victim line becomes I on WB1 completion.
- **FETCH0/FETCH1:**
  - Outputs: `dREN`=1, `cctrans`=1, `ccwrite` = `dmemWEN`, `daddr` = request base + 0/4.
  - Latch `dload` on `dwait`=0.
  - FETCH1 completion writes tag and state (S for a read, M for a write), then → IDLE. The retried access hits on the next cycle.
  - An upgrade miss refetches the block with `ccwrite`=1. This is the controller's invalidation trigger for the peer.
- **Snoop port:** independent of the FSM and evaluated every cycle with `ccwait`=1.
  - Snoop hit: tag match and state ≠ I.
  - Hit in M: `cctrans`=1 and `dstore` = word selected by `ccsnoopaddr[2]`.
  - Snoop miss, or hit in S: `cctrans`=0 and `dstore`=0.
  - At the clock edge: `ccinv`=1 → line becomes I. `ccinv`=0 and line M → line becomes S.
- While `ccwait`=1, `dhit` is forced to 0 and array writes from the datapath are blocked.
- **Flush:**
  - FLUSH_CHK walks a 4-bit set counter from 0 to 15.
  - M line → FLUSH_WB0/WB1: `dWEN`, two words, then the line becomes I.
  - Otherwise the line is marked I and the counter increments.
  - After set 15 → DONE: `flushed`=1, all bus requests 0.
- `dREN` and `dWEN` are never both 1. `dREN`=`dWEN`=0 in IDLE and DONE.

## Timing
- **Reset (async):** all lines I, FSM IDLE, set counter 0. All outputs 0: `dhit`, `dREN`, `dWEN`, `cctrans`, `ccwrite`, `evict`, `flushed`, `daddr`, `dstore`, `dmemload`.
- **Hit:** 0-cycle latency. The store is visible to a load on the next cycle.
- **Clean miss:** FETCH0 and FETCH1 each last ≥1 cycle (held until `dwait`=0), then one IDLE hit cycle. Minimum 3 cycles request-to-`dhit`.
- **Dirty miss:** adds WB0 and WB1, ≥2 more cycles. `evict` is high exactly during WB0/WB1.
- Bus outputs are held stable while `dwait`=1.
- **Snoop during own WB/FETCH:**
  - The snoop is still answered.
  - If the snoop invalidates the fetching set, the fill result overwrites it at FETCH1 completion.
  - A snoop on the victim set during WB leaves the victim becoming I.
- A snoop and a datapath request in the same cycle: the snoop wins, and the request waits.
- `halt` asserted mid-miss: the current miss completes to IDLE, then the flush starts.
- Reset mid-transaction aborts immediately. No partial line is marked valid.

## Test plan
- Read miss at 0x0000_0104 with memory returning 0xAAAA0000/0xAAAA0004:
  - `dREN` at 0x100, then 0x104.
  - Line becomes S.
  - Next cycle `dhit`=1 with `dmemload`=0xAAAA0004.
- Write 0x12345678 to 0x104 (line S):
  - Upgrade fetch with `cctrans`=`ccwrite`=1.
  - Line becomes M.
  - A following load returns 0x12345678.
- Snoop on the M line at 0x104, `ccinv`=0:
  - `cctrans`=1 and `dstore`=0x12345678.
  - Line becomes S. A datapath write to it now misses.
  - Repeat with `ccinv`=1: line becomes I.
- Conflict miss at 0x0000_0184 (same set, M victim):
  - `evict`=1 with `dWEN` at 0x100/0x104 and the victim data.
  - Then fetch of 0x180/0x184.
- `halt` with sets 2 and 9 dirty:
  - Exactly 4 `dWEN` words, to those sets' addresses.
  - Then `flushed`=1, held until reset.
- Assert `nRST`=0 during FETCH1:
  - All outputs 0 immediately.
  - After release, a read to the same address misses again.
